// File: rtl/cfu_pkg.sv
// Shared constants and state encoding for the requantize/pack post-processing stage.
package cfu_pkg;

  localparam int LANES       = 4;
  localparam int ACC_W       = 32;
  localparam int ACT_W       = 8;
  localparam int RSHIFT_BASE = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/requant_lane.sv
// One lane of requantization: rounding right shift of a registered Q31 product,
// output offset, then clamp to the activation range.
module requant_lane
  import cfu_pkg::*;
#(
  parameter int SHIFT_BITS = 4
) (
  input  logic signed [2*ACC_W-1:0] prod_i,
  input  logic        [SHIFT_BITS-1:0] shift_i,
  input  logic signed [8:0]         offset_i,
  input  logic signed [ACT_W-1:0]   act_min_i,
  input  logic signed [ACT_W-1:0]   act_max_i,
  output logic        [ACT_W-1:0]   y_o
);

  logic signed [63:0] rnd_s;
  logic signed [63:0] sum_s;
  logic signed [63:0] scaled_s;
  logic signed [63:0] t_s;
  logic signed [63:0] lo_s;
  logic signed [63:0] hi_s;

  // Half-up rounding: add half an LSB of the result before the arithmetic shift.
  always_comb begin
    rnd_s    = 64'sd1 <<< (RSHIFT_BASE - 1 + int'(shift_i));
    sum_s    = prod_i + rnd_s;
    scaled_s = sum_s >>> (RSHIFT_BASE + int'(shift_i));
    t_s      = scaled_s + 64'(offset_i);
    lo_s     = 64'(act_min_i);
    hi_s     = 64'(act_max_i);
    if (act_min_i > act_max_i) begin
      y_o = act_max_i;
    end else if (t_s > hi_s) begin
      y_o = act_max_i;
    end else if (t_s < lo_s) begin
      y_o = act_min_i;
    end else begin
      y_o = t_s[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/requant_pack_unit.sv
// Streams int32 accumulator rows out of the C buffer, requantizes four lanes per row
// and writes each row as one packed int8 word; launched by a single start pulse.
module requant_pack_unit
  import cfu_pkg::*;
#(
  parameter int C_ADDR_BITS   = 8,
  parameter int C_DATA_BITS   = 128,
  parameter int OUT_ADDR_BITS = 8,
  parameter int SHIFT_BITS    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [C_ADDR_BITS:0]     row_count,
  input  logic [C_ADDR_BITS-1:0]   c_base,
  input  logic [OUT_ADDR_BITS-1:0] out_base,
  input  logic [31:0]              multiplier,
  input  logic [SHIFT_BITS-1:0]    shift,
  input  logic [8:0]               out_offset,
  input  logic [7:0]               act_min,
  input  logic [7:0]               act_max,
  output logic                     busy,
  output logic                     done,
  output logic [C_ADDR_BITS-1:0]   C_index,
  input  logic [C_DATA_BITS-1:0]   C_data_out,
  output logic                     out_wr_en,
  output logic [OUT_ADDR_BITS-1:0] out_index,
  output logic [31:0]              out_data
);

  localparam logic [C_ADDR_BITS:0] ROW_ONE = (C_ADDR_BITS+1)'(1);

  state_e                    state_q;
  logic [C_ADDR_BITS:0]      rem_q;
  logic [C_ADDR_BITS-1:0]    c_index_q;
  logic [OUT_ADDR_BITS-1:0]  out_ptr_q;
  logic [OUT_ADDR_BITS-1:0]  out_index_q;
  logic signed [ACC_W-1:0]   mult_q;
  logic [SHIFT_BITS-1:0]     shift_q;
  logic signed [8:0]         offset_q;
  logic signed [ACT_W-1:0]   min_q;
  logic signed [ACT_W-1:0]   max_q;
  logic                      dv_q;
  logic                      pv_q;
  logic                      wr_en_q;
  logic                      busy_q;
  logic                      done_q;
  logic [LANES*ACT_W-1:0]    out_data_q;
  logic [LANES*ACT_W-1:0]    out_data_d;
  logic signed [2*ACC_W-1:0] prod_q [LANES];
  logic signed [2*ACC_W-1:0] prod_d [LANES];
  logic [ACT_W-1:0]          y_s    [LANES];

  // Lane 0 sits in the MSBs of both the C row and the packed output word.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [ACC_W-1:0] acc_s;
    assign acc_s     = C_data_out[C_DATA_BITS-1-ACC_W*j -: ACC_W];
    assign prod_d[j] = 64'(acc_s) * 64'(mult_q);

    requant_lane #(.SHIFT_BITS(SHIFT_BITS)) u_lane (
      .prod_i    (prod_q[j]),
      .shift_i   (shift_q),
      .offset_i  (offset_q),
      .act_min_i (min_q),
      .act_max_i (max_q),
      .y_o       (y_s[j])
    );

    assign out_data_d[LANES*ACT_W-1-ACT_W*j -: ACT_W] = y_s[j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      c_index_q   <= '0;
      out_ptr_q   <= '0;
      out_index_q <= '0;
      mult_q      <= '0;
      shift_q     <= '0;
      offset_q    <= '0;
      min_q       <= '0;
      max_q       <= '0;
      dv_q        <= 1'b0;
      pv_q        <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      for (int j = 0; j < LANES; j++) prod_q[j] <= '0;
    end else begin
      // Valid bits march alongside the index -> data -> product -> write stages.
      dv_q    <= (state_q == ST_ISSUE);
      pv_q    <= dv_q;
      wr_en_q <= pv_q;
      done_q  <= 1'b0;
      if (dv_q) begin
        for (int j = 0; j < LANES; j++) prod_q[j] <= prod_d[j];
      end
      if (pv_q) begin
        out_data_q  <= out_data_d;
        out_index_q <= out_ptr_q;
        out_ptr_q   <= out_ptr_q + OUT_ADDR_BITS'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mult_q    <= $signed(multiplier);
            shift_q   <= shift;
            offset_q  <= $signed(out_offset);
            min_q     <= $signed(act_min);
            max_q     <= $signed(act_max);
            out_ptr_q <= out_base;
            busy_q    <= 1'b1;
            if (row_count == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_ISSUE;
              c_index_q <= c_base;
              rem_q     <= row_count - ROW_ONE;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (rem_q == '0) begin
            state_q <= ST_DRAIN;
          end else begin
            c_index_q <= c_index_q + C_ADDR_BITS'(1);
            rem_q     <= rem_q - ROW_ONE;
          end
        end
        ST_DRAIN: begin
          // Final write is already in its output register once both earlier stages are empty.
          if (!dv_q && !pv_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign C_index   = c_index_q;
  assign out_wr_en = wr_en_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_requant_pack_unit.sv
// Randomized bench for requant_pack_unit: per-cycle comparison against a cycle-scheduled
// arithmetic model, plus directed rounding/clamp/shift/streaming/reset scenarios.
module tb_requant_pack_unit;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [8:0]   row_count = '0;
  logic [7:0]   c_base = '0;
  logic [7:0]   out_base = '0;
  logic [31:0]  multiplier = '0;
  logic [3:0]   shift = '0;
  logic [8:0]   out_offset = '0;
  logic [7:0]   act_min = '0;
  logic [7:0]   act_max = '0;
  logic         busy, done, out_wr_en;
  logic [7:0]   C_index, out_index;
  logic [127:0] C_data_out = '0;
  logic [31:0]  out_data;

  logic [127:0] cmem [256];
  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  bit [31:0] ew_data [int];
  bit [7:0]  ew_idx  [int];
  bit [7:0]  ec_idx  [int];
  bit        ed      [int];
  bit        eb      [int];

  int          lw_cyc = -1;
  logic [31:0] lw_data = '0;
  logic [7:0]  lw_idx = '0;

  requant_pack_unit dut (
    .clk(clk), .reset(reset), .start(start), .row_count(row_count),
    .c_base(c_base), .out_base(out_base), .multiplier(multiplier), .shift(shift),
    .out_offset(out_offset), .act_min(act_min), .act_max(act_max),
    .busy(busy), .done(done), .C_index(C_index), .C_data_out(C_data_out),
    .out_wr_en(out_wr_en), .out_index(out_index), .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    C_data_out <= cmem[C_index];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // floor((acc*mult + 2^(30+sh)) / 2^(31+sh)) + off, then clamp with the max bound winning
  function automatic logic [7:0] model_lane(input longint acc, input longint mult, input int sh,
                                            input longint off, input longint mn, input longint mx);
    longint d, num, q, t;
    d   = longint'(1) << (31 + sh);
    num = acc * mult + d / 2;
    q   = num / d;
    if ((num % d != 0) && (num < 0)) q = q - 1;
    t = q + off;
    if (mn > mx)     t = mx;
    else if (t > mx) t = mx;
    else if (t < mn) t = mn;
    return t[7:0];
  endfunction

  function automatic logic [31:0] model_word(input logic [127:0] row, input logic [31:0] mult,
                                             input logic [3:0] sh, input logic [8:0] off,
                                             input logic [7:0] mn, input logic [7:0] mx);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      w[31-8*j -: 8] = model_lane(longint'($signed(row[127-32*j -: 32])), longint'($signed(mult)),
                                  int'(sh), longint'($signed(off)), longint'($signed(mn)),
                                  longint'($signed(mx)));
    return w;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit we_exp;
        we_exp = ew_data.exists(cyc) ? 1'b1 : 1'b0;
        check("wr_en", 32'(out_wr_en), 32'(we_exp));
        if (we_exp && out_wr_en) begin
          check("wr_idx", 32'(out_index), 32'(ew_idx[cyc]));
          check("wr_data", out_data, ew_data[cyc]);
        end
        if (out_wr_en) begin
          lw_cyc  = cyc;
          lw_data = out_data;
          lw_idx  = out_index;
        end
        check("done", 32'(done), 32'(ed.exists(cyc) ? 1 : 0));
        check("busy", 32'(busy), 32'(eb.exists(cyc) ? 1 : 0));
        if (ec_idx.exists(cyc)) check("c_index", 32'(C_index), 32'(ec_idx[cyc]));
      end
    end
  endtask

  task automatic launch(input int rows, input logic [7:0] cb, input logic [7:0] ob,
                        input logic [31:0] mult, input logic [3:0] sh, input logic [8:0] off,
                        input logic [7:0] mn, input logic [7:0] mx, output int c0, output int cdone);
    @(negedge clk);
    row_count = 9'(rows); c_base = cb; out_base = ob; multiplier = mult;
    shift = sh; out_offset = off; act_min = mn; act_max = mx; start = 1'b1;
    c0 = cyc + 1;
    if (rows == 0) begin
      cdone = c0;
    end else begin
      for (int n = 0; n < rows; n++) begin
        logic [7:0] ci, oi;
        ci = cb + 8'(n);
        oi = ob + 8'(n);
        ec_idx[c0+n]    = ci;
        ew_idx[c0+n+3]  = oi;
        ew_data[c0+n+3] = model_word(cmem[ci], mult, sh, off, mn, mx);
      end
      cdone = c0 + rows + 3;
    end
    for (int c = c0; c <= cdone; c++) eb[c] = 1'b1;
    ed[cdone] = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // inputs are latched; wiggle them to prove later changes are ignored
    row_count = 9'($urandom); c_base = 8'($urandom); out_base = 8'($urandom);
    multiplier = $urandom; shift = 4'($urandom); out_offset = 9'($urandom);
    act_min = 8'($urandom); act_max = 8'($urandom);
  endtask

  task automatic wait_idle(input int cdone);
    while (cyc <= cdone) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_acc();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($signed($urandom_range(0, 2000)) - 1000);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c0, cd, prev_lw;
    for (int i = 0; i < 256; i++) cmem[i] = {$urandom, $urandom, $urandom, $urandom};
    fork monitor(); join_none

    check("pin_round_pos", 32'(model_lane(100, 64'h4000_0000, 0, 0, -128, 127)), 32'd50);
    check("pin_round_neg", 32'(model_lane(-101, 64'h4000_0000, 0, 0, -128, 127)), 32'h0000_00CE);
    check("pin_shift", 32'(model_lane(100, 64'h4000_0000, 2, 0, -128, 127)), 32'd13);
    check("pin_clamp", 32'(model_lane(300, 64'h7FFF_FFFF, 0, -128, -128, 127)), 32'h0000_007F);
    check("pin_inverted", 32'(model_lane(0, 64'h4000_0000, 0, 0, 10, -5)), 32'h0000_00FB);

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(out_wr_en), 32'd0);
    check("rst_c_index", 32'(C_index), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    cmem[8'h20] = {32'd100, 32'd101, 32'hFFFF_FF9B, 32'd0};
    launch(1, 8'h20, 8'h40, 32'h4000_0000, 4'd0, 9'd0, 8'h80, 8'h7F, c0, cd);
    wait_idle(cd);
    check("t1_data", lw_data, 32'h3233_CE00);
    check("t1_idx", 32'(lw_idx), 32'h40);
    check("t1_latency", 32'(lw_cyc - c0), 32'd3);

    cmem[8'h21] = {32'h7FFF_FFFF, 32'd0, 32'd300, 32'hFFFF_FED4};
    launch(1, 8'h21, 8'h41, 32'h7FFF_FFFF, 4'd0, 9'h180, 8'h80, 8'h7F, c0, cd);
    wait_idle(cd);
    check("t2_data", lw_data, 32'h7F80_7F80);

    cmem[8'h22] = {32'd100, 32'd0, 32'd0, 32'd0};
    launch(1, 8'h22, 8'h42, 32'h4000_0000, 4'd2, 9'd0, 8'h80, 8'h7F, c0, cd);
    wait_idle(cd);
    check("t3_data", lw_data, 32'h0D00_0000);

    launch(3, 8'hFE, 8'h10, $urandom, 4'd1, 9'd3, 8'h80, 8'h7F, c0, cd);
    wait_idle(cd);
    check("t4_last_idx", 32'(lw_idx), 32'h12);
    check("t4_last_cyc", 32'(lw_cyc - c0), 32'd5);
    check("t4_done_after", 32'(cd - lw_cyc), 32'd1);

    prev_lw = lw_cyc;
    launch(0, 8'h00, 8'h00, 32'h4000_0000, 4'd0, 9'd0, 8'h80, 8'h7F, c0, cd);
    wait_idle(cd + 3);
    check("t5_no_write", 32'(lw_cyc), 32'(prev_lw));

    launch(4, 8'h30, 8'h50, 32'h2000_0000, 4'd0, 9'd5, 8'hF0, 8'h40, c0, cd);
    @(negedge clk);
    start = 1'b1; c_base = 8'h99; out_base = 8'h77; row_count = 9'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle(cd);
    check("t5_busy_start_idx", 32'(lw_idx), 32'h53);

    launch(5, 8'h60, 8'h20, 32'h3000_0000, 4'd0, 9'd0, 8'h80, 8'h7F, c0, cd);
    while (cyc < c0 + 3) @(negedge clk);
    reset = 1'b1;
    for (int c = c0 + 4; c <= cd; c++) begin
      if (ew_data.exists(c)) ew_data.delete(c);
      if (ew_idx.exists(c))  ew_idx.delete(c);
      if (ec_idx.exists(c))  ec_idx.delete(c);
      if (ed.exists(c))      ed.delete(c);
      if (eb.exists(c))      eb.delete(c);
    end
    @(negedge clk);
    check("t6_c_index", 32'(C_index), 32'd0);
    check("t6_out_index", 32'(out_index), 32'd0);
    check("t6_out_data", out_data, 32'd0);
    check("t6_wr_en", 32'(out_wr_en), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    launch(2, 8'h70, 8'h08, 32'h5000_0000, 4'd3, 9'h1F0, 8'h90, 8'h60, c0, cd);
    wait_idle(cd);
    check("t6_rerun_idx", 32'(lw_idx), 32'h09);

    repeat (25) begin
      int rows;
      for (int i = 0; i < 256; i++) cmem[i] = {rand_acc(), rand_acc(), rand_acc(), rand_acc()};
      rows = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8));
      launch(rows, 8'($urandom), 8'($urandom), $urandom, 4'($urandom), 9'($urandom),
             8'($urandom), 8'($urandom), c0, cd);
      wait_idle(cd);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
